// File: rtl/acq_sequencer.sv
// acq_sequencer: paces the ADC sampler, stores each sample in the sample RAM, then replays the run to the serial transmitter.
// Define ACQ_TIMEOUT_EN to add a watchdog on the sampler/transmitter handshakes (sets err and aborts to DONE).
module acq_sequencer #(
  parameter int SAMPLE_PERIOD  = 500,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [6:0]  sample_limit,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [11:0] wr_data,
  output logic [6:0]  rd_addr,
  input  logic [11:0] rd_data,
  output logic        tx_start,
  output logic [11:0] tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  count
);

  // state | meaning
  // IDLE  | waiting for an arm edge after reset
  // PACE  | waiting for the pacing counter to reach the sample slot
  // CONV  | conversion in flight, waiting for adc_done
  // STORE | sample being written to RAM
  // FETCH | RAM read address presented
  // LOAD  | RAM read data captured into tx_data
  // SEND  | word handed to the transmitter, waiting for tx_done
  // DONE  | run finished (or aborted); waiting for the next arm edge
  typedef enum logic [2:0] {
    S_IDLE, S_PACE, S_CONV, S_STORE, S_FETCH, S_LOAD, S_SEND, S_DONE
  } state_t;

  localparam logic [15:0] PACE_LAST = 16'(SAMPLE_PERIOD - 1);

  state_t      state;
  logic        arm_q;
  logic [6:0]  limit;
  logic [15:0] pace_cnt;
  logic [6:0]  count_inc;
  logic        arm_edge;
  logic        pace_wrap;

  assign arm_edge  = arm && !arm_q;
  assign pace_wrap = (pace_cnt == PACE_LAST);
  assign count_inc = count + 7'd1;

`ifdef ACQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_LAST);
  assign err        = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      arm_q     <= 1'b0;
      limit     <= '0;
      pace_cnt  <= '0;
      count     <= '0;
      adc_start <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      arm_q     <= arm;
      adc_start <= 1'b0;
      wr_en     <= 1'b0;
      tx_start  <= 1'b0;

      // Pacing is free-running across the whole capture phase so slots stay exactly SAMPLE_PERIOD apart.
      if (state == S_PACE || state == S_CONV || state == S_STORE)
        pace_cnt <= pace_wrap ? '0 : pace_cnt + 16'd1;
`ifdef ACQ_TIMEOUT_EN
      if (state == S_CONV || state == S_SEND)
        wd_cnt <= wd_cnt + WD_W'(1);
`endif

      case (state)
        S_IDLE, S_DONE: begin
          if (arm_edge) begin
            limit    <= sample_limit;
            count    <= '0;
            pace_cnt <= '0;
`ifdef ACQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            if (sample_limit == 7'd0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_PACE;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_PACE: begin
          if (pace_wrap) begin
            adc_start <= 1'b1;
            state     <= S_CONV;
`ifdef ACQ_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
          end
        end
        S_CONV: begin
          // A done coinciding with our own start pulse belongs to no conversion of ours.
          if (adc_done && !adc_start) begin
            wr_en   <= 1'b1;
            wr_addr <= count;
            wr_data <= adc_data;
            state   <= S_STORE;
          end
`ifdef ACQ_TIMEOUT_EN
          else if (wd_expired) begin
            err_q <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
        end
        S_STORE: begin
          if (count_inc == limit) begin
            count   <= '0;
            rd_addr <= '0;
            state   <= S_FETCH;
          end else begin
            count <= count_inc;
            state <= S_PACE;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          tx_data  <= rd_data;
          tx_start <= 1'b1;
          state    <= S_SEND;
`ifdef ACQ_TIMEOUT_EN
          wd_cnt   <= '0;
`endif
        end
        S_SEND: begin
          if (tx_done) begin
            count <= count_inc;
            if (count_inc == limit) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_addr <= count_inc;
              state   <= S_FETCH;
            end
          end
`ifdef ACQ_TIMEOUT_EN
          else if (wd_expired) begin
            err_q <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: sampler, RAM and transmitter models plus a write/transmit scoreboard.
module tb_acq_sequencer;
  localparam int SP      = 24;
  localparam int TO      = 100;
  localparam int ADC_LAT = 3;
  localparam int TX_LAT  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic [6:0]  sample_limit = '0;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [11:0] wr_data;
  logic [6:0]  rd_addr;
  logic [11:0] rd_data = '0;
  logic        tx_start;
  logic [11:0] tx_data;
  logic        tx_done = 1'b0;
  logic        busy, done, err;
  logic [6:0]  count;

  acq_sequencer #(.SAMPLE_PERIOD(SP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_limit(sample_limit),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [18:0] exp_wr[$];
  logic [11:0] exp_tx[$];
  logic [11:0] adc_vals[$];
  int          adc_times[$];

  int          adc_start_n = 0, wr_n = 0, tx_n = 0;
  int          last_wr_cyc = -100, last_txdone_cyc = -100;
  logic [6:0]  max_wr = '0, max_rd = '0;
  logic        sampler_en = 1'b1, tx_hold = 1'b0, late_done_req = 1'b0;
  int          adc_cnt = 0, tx_cnt = 0;
  logic [11:0] tx_latched = '0;
  logic [11:0] mem [128];
  logic [11:0] rd_pipe = '0;

  // Sampler model: answers each adc_start after ADC_LAT cycles with the next queued value.
  initial forever begin
    @(negedge clk);
    adc_done = 1'b0;
    if (rst) adc_cnt = 0;
    else if (adc_start && sampler_en) adc_cnt = ADC_LAT;
    else if (adc_cnt > 0) begin
      adc_cnt--;
      if (adc_cnt == 0) begin
        adc_done = 1'b1;
        adc_data = (adc_vals.size() > 0) ? adc_vals.pop_front() : 12'hFFF;
      end
    end
  end

  // Sample RAM model: writes land immediately, reads appear one cycle after the address.
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 12'hEEE;
    forever begin
      @(negedge clk);
      rd_data = rd_pipe;
      rd_pipe = mem[rd_addr];
      if (wr_en) mem[wr_addr] = wr_data;
    end
  end

  // Transmitter model: completes TX_LAT cycles after tx_start, checking tx_data holds meanwhile.
  initial forever begin
    @(negedge clk);
    tx_done = 1'b0;
    if (late_done_req) begin
      tx_done = 1'b1;
      late_done_req = 1'b0;
    end else if (rst) tx_cnt = 0;
    else if (tx_start) begin
      tx_cnt = TX_LAT;
      tx_latched = tx_data;
    end else if (tx_cnt > 0 && !tx_hold) begin
      tests_run++;
      if (tx_data !== tx_latched) begin
        tests_failed++;
        $display("FAIL tx_data_hold: got %h required %h", tx_data, tx_latched);
      end
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        last_txdone_cyc = cyc;
      end
    end
  end

  // Output monitor: pops scoreboard entries as the DUT writes and transmits.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rd_addr > max_rd) max_rd = rd_addr;
      if (adc_start) begin
        adc_start_n++;
        adc_times.push_back(cyc);
      end
      if (wr_en) begin
        logic [18:0] got, want;
        wr_n++;
        last_wr_cyc = cyc;
        if (wr_addr > max_wr) max_wr = wr_addr;
        got = {wr_addr, wr_data};
        tests_run++;
        if (exp_wr.size() == 0) begin
          tests_failed++;
          $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
        end else begin
          want = exp_wr.pop_front();
          if (got !== want) begin
            tests_failed++;
            $display("FAIL wr_entry: got addr=%0d data=%h, required addr=%0d data=%h",
                     got[18:12], got[11:0], want[18:12], want[11:0]);
          end
        end
      end
      if (tx_start) begin
        int prev;
        tx_n++;
        tests_run++;
        if (exp_tx.size() == 0) begin
          tests_failed++;
          $display("FAIL tx_unexpected: got tx_data=%h, required no tx_start", tx_data);
        end else begin
          logic [11:0] want;
          want = exp_tx.pop_front();
          if (tx_data !== want) begin
            tests_failed++;
            $display("FAIL tx_data: got %h required %h", tx_data, want);
          end
        end
        prev = (last_txdone_cyc > last_wr_cyc) ? last_txdone_cyc : last_wr_cyc;
        tests_run++;
        if (cyc - prev != 3) begin
          tests_failed++;
          $display("FAIL tx_gap: got %0d cycles required 3", cyc - prev);
        end
      end
    end
  end

  task automatic do_arm(input logic [6:0] lim, output int edge_cyc);
    @(negedge clk);
    sample_limit = lim;
    arm = 1'b1;
    edge_cyc = cyc + 1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int seen_cyc);
    seen_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (done && seen_cyc < 0) seen_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({adc_start, wr_en, tx_start, busy, done, err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 000000", {adc_start, wr_en, tx_start, busy, done, err});
    end
    tests_run++;
    if ({wr_addr, wr_data, rd_addr, tx_data} !== 38'b0) begin
      tests_failed++;
      $display("FAIL reset_bus: got %h required 0", {wr_addr, wr_data, rd_addr, tx_data});
    end
    tests_run++;
    if (count !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_count: got %0d required 0", count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [11:0] v [3];
    int e, t, tx0;
    v = '{12'h0A1, 12'h0B2, 12'h0C3};
    for (int i = 0; i < 3; i++) begin
      adc_vals.push_back(v[i]);
      exp_wr.push_back({7'(i), v[i]});
      exp_tx.push_back(v[i]);
    end
    adc_times.delete();
    tx0 = tx_n;
    do_arm(7'd3, e);
    wait_done(1000, t);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_status: got done=%b busy=%b err=%b required 1 0 0", done, busy, err);
    end
    tests_run++;
    if (count !== 7'd3) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d required 3", count);
    end
    tests_run++;
    if (adc_times.size() != 3) begin
      tests_failed++;
      $display("FAIL basic_adc_pulses: got %0d required 3", adc_times.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (adc_times[k] != e + SP * (k + 1)) begin
          tests_failed++;
          $display("FAIL basic_adc_time%0d: got %0d required %0d", k, adc_times[k] - e, SP * (k + 1));
        end
      end
    end
    tests_run++;
    if (tx_n - tx0 != 3 || exp_wr.size() != 0 || exp_tx.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_scoreboard: got tx=%0d wr_left=%0d tx_left=%0d required 3 0 0",
               tx_n - tx0, exp_wr.size(), exp_tx.size());
    end
  endtask

  task automatic test_empty();
    int e, a0, t0, w0;
    a0 = adc_start_n; t0 = tx_n; w0 = wr_n;
    do_arm(7'd0, e);
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 7'd0) begin
      tests_failed++;
      $display("FAIL empty_status: got done=%b busy=%b count=%0d required 1 0 0", done, busy, count);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (adc_start_n != a0 || tx_n != t0 || wr_n != w0) begin
      tests_failed++;
      $display("FAIL empty_activity: got adc=%0d tx=%0d wr=%0d required 0 0 0",
               adc_start_n - a0, tx_n - t0, wr_n - w0);
    end
  endtask

  task automatic test_full();
    int e, t, tx0;
    for (int i = 0; i < 127; i++) begin
      adc_vals.push_back(12'(i));
      exp_wr.push_back({7'(i), 12'(i)});
      exp_tx.push_back(12'(i));
    end
    max_wr = '0;
    max_rd = '0;
    tx0 = tx_n;
    do_arm(7'd127, e);
    wait_done(8000, t);
    tests_run++;
    if (done !== 1'b1 || count !== 7'd127) begin
      tests_failed++;
      $display("FAIL full_status: got done=%b count=%0d required 1 127", done, count);
    end
    tests_run++;
    if (max_wr !== 7'd126 || max_rd !== 7'd126) begin
      tests_failed++;
      $display("FAIL full_addr_max: got wr=%0d rd=%0d required 126 126", max_wr, max_rd);
    end
    tests_run++;
    if (tx_n - tx0 != 127 || exp_wr.size() != 0 || exp_tx.size() != 0) begin
      tests_failed++;
      $display("FAIL full_scoreboard: got tx=%0d wr_left=%0d tx_left=%0d required 127 0 0",
               tx_n - tx0, exp_wr.size(), exp_tx.size());
    end
  endtask

  task automatic test_mid_run();
    int e, t, w0;
    for (int i = 0; i < 4; i++) begin
      adc_vals.push_back(12'h100 + 12'(i));
      exp_wr.push_back({7'(i), 12'h100 + 12'(i)});
      exp_tx.push_back(12'h100 + 12'(i));
    end
    w0 = wr_n;
    do_arm(7'd4, e);
    repeat (30) @(negedge clk);
    do_arm(7'd9, e);
    wait_done(1500, t);
    tests_run++;
    if (done !== 1'b1 || count !== 7'd4 || wr_n - w0 != 4) begin
      tests_failed++;
      $display("FAIL midrun_limit: got done=%b count=%0d writes=%0d required 1 4 4", done, count, wr_n - w0);
    end
    for (int i = 0; i < 2; i++) begin
      adc_vals.push_back(12'h200 + 12'(i));
      exp_wr.push_back({7'(i), 12'h200 + 12'(i)});
      exp_tx.push_back(12'h200 + 12'(i));
    end
    do_arm(7'd2, e);
    tests_run++;
    if (count !== 7'd0 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rearm_start: got count=%0d busy=%b done=%b required 0 1 0", count, busy, done);
    end
    wait_done(1000, t);
    tests_run++;
    if (done !== 1'b1 || count !== 7'd2 || exp_wr.size() != 0 || exp_tx.size() != 0) begin
      tests_failed++;
      $display("FAIL rearm_finish: got done=%b count=%0d wr_left=%0d tx_left=%0d required 1 2 0 0",
               done, count, exp_wr.size(), exp_tx.size());
    end
  endtask

  task automatic test_rst_send();
    int e, t0;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      adc_vals.push_back(12'h3C1 + 12'(i));
      exp_wr.push_back({7'(i), 12'h3C1 + 12'(i)});
      exp_tx.push_back(12'h3C1 + 12'(i));
    end
    tx_hold = 1'b1;
    t0 = tx_n;
    do_arm(7'd2, e);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      if (tx_n != t0) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL rst_send_reach: got no tx_start in 500 cycles required 1");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({adc_start, wr_en, tx_start, busy, done, err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL rst_send_ctrl: got %b required 000000", {adc_start, wr_en, tx_start, busy, done, err});
    end
    tests_run++;
    if ({wr_addr, wr_data, rd_addr, tx_data, count} !== 45'b0) begin
      tests_failed++;
      $display("FAIL rst_send_bus: got %h required 0", {wr_addr, wr_data, rd_addr, tx_data, count});
    end
    rst = 1'b0;
    tx_hold = 1'b0;
    late_done_req = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== 7'd0 || tx_n - t0 != 1 || exp_tx.size() != 1) begin
      tests_failed++;
      $display("FAIL rst_send_late_done: got busy=%b done=%b count=%0d tx=%0d tx_left=%0d required 0 0 0 1 1",
               busy, done, count, tx_n - t0, exp_tx.size());
    end
    exp_tx.delete();
    exp_wr.delete();
  endtask

  task automatic test_timeout();
    int e, t, s;
    sampler_en = 1'b0;
    adc_times.delete();
    do_arm(7'd1, e);
    for (int i = 0; i < 100; i++) begin
      if (adc_times.size() > 0) break;
      @(negedge clk);
    end
    tests_run++;
    if (adc_times.size() == 0) begin
      tests_failed++;
      $display("FAIL timeout_start: got no adc_start required 1");
      s = cyc;
    end else s = adc_times[0];
`ifdef ACQ_TIMEOUT_EN
    wait_done(300, t);
    tests_run++;
    if (t != s + TO) begin
      tests_failed++;
      $display("FAIL timeout_latency: got %0d required %0d", t - s, TO);
    end
    tests_run++;
    if (err !== 1'b1 || done !== 1'b1 || count !== 7'd0) begin
      tests_failed++;
      $display("FAIL timeout_status: got err=%b done=%b count=%0d required 1 1 0", err, done, count);
    end
`else
    t = 0;
    repeat (300) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_timeout_wait: got busy=%b done=%b err=%b required 1 0 0", busy, done, err);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sampler_en = 1'b1;
    adc_vals.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_full();
    test_mid_run();
    test_rst_send();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at 2 ms, required finish");
    $fatal(1);
  end

endmodule

// File: doc/acq_sequencer.md
# acq_sequencer

Run controller for the sample-and-forward chain. It paces the 12-bit ADC sampler and writes each sample into an external 128x12 sample RAM. It then replays the stored samples, in capture order, into the 12-bit Arduino serial transmitter. The block sits between the top-level run control (arm/status) and the sampler, RAM and transmitter, replacing hard-coded run sequencing with a handshaked, limit-programmable FSM.

## Interface
- SAMPLE_PERIOD, 500: clk cycles between consecutive `adc_start` pulses (50 MHz → 100 kS/s); legal 24..65535.
- TIMEOUT_CYCLES, 4096: watchdog limit per sampler/transmitter transaction (used only with ACQ_TIMEOUT_EN).
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- arm  in  1  level-sampled; rising edge in IDLE or DONE starts a run.
- sample_limit  in  7  samples per run, latched at run start; 0 = empty run.
- adc_start  out  1  one-cycle pulse; sampler begins a conversion.
- adc_done  in  1  one-cycle pulse; `adc_data` valid this cycle.
- adc_data  in  12  conversion result.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  7  RAM write address.
- wr_data  out  12  RAM write data.
- rd_addr  out  7  RAM read address; `rd_data` valid exactly one cycle later.
- rd_data  in  12  RAM read data.
- tx_start  out  1  one-cycle pulse; transmitter latches `tx_data`.
- tx_data  out  12  word to transmit, held stable from `tx_start` until `tx_done`.
- tx_done  in  1  one-cycle pulse; transmit complete.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- err  out  1  sticky watchdog abort flag.
- count  out  7  samples collected (capture phase) or transmitted (replay phase).

## Operation
- States: IDLE, PACE, CONV, STORE, FETCH, LOAD, SEND, DONE.
- IDLE/DONE: on an `arm` rising edge (registered previous value), latch `sample_limit` and clear `count`, `err` and the pacing counter.
  - If the latched limit is 0, go to DONE; otherwise go to PACE.
- PACE: the pacing counter runs from run start. When it reaches SAMPLE_PERIOD-1, pulse `adc_start`, reload the counter to 0 and go to CONV. The counter keeps free-running in all capture states, so samples are spaced exactly SAMPLE_PERIOD cycles apart.
- CONV: wait for `adc_done`, then go to STORE with the sample registered.
- STORE: `wr_en`=1, `wr_addr`=`count`, `wr_data`=sample; increment `count`.
  - If new `count` == limit: clear `count` and go to FETCH.
  - Otherwise go to PACE.
- FETCH: drive `rd_addr`=`count`, go to LOAD.
- LOAD: register `rd_data` into `tx_data`, go to SEND.
- SEND: pulse `tx_start` on the first SEND cycle only, then wait for `tx_done`. On `tx_done`, increment `count`.
  - If new `count` == limit: go to DONE.
  - Otherwise go to FETCH.
- DONE: hold `count` at the limit; `done`=1 until the next arm edge.
- `adc_done` outside CONV and `tx_done` outside SEND are ignored.
- Arm edges while `busy` are ignored.
- `sample_limit` changes mid-run have no effect.
- Counts are 7-bit unsigned; max limit 127, so addresses never wrap.

## Timing
- Reset values: `adc_start`, `wr_en`, `tx_start`, `busy`, `done` and `err` are 0; `wr_addr`, `wr_data`, `rd_addr`, `tx_data` and `count` are 0; state is IDLE.
- `rst` overrides everything, including mid-conversion or mid-transmit. External engines are not notified.
- First `adc_start` occurs SAMPLE_PERIOD cycles after the cycle that registers the arm edge.
- `wr_en` is asserted 1 cycle after `adc_done`.
- First `tx_start` occurs 3 cycles after the final STORE (FETCH, LOAD, SEND).
- The next `tx_start` occurs 3 cycles after each `tx_done`.
- All outputs are registered; no combinational input-to-output paths.
- `adc_done` arriving in the same cycle as an `adc_start` pulse is not accepted; CONV is entered on the next cycle.

## Configuration
- ACQ_TIMEOUT_EN defined: a watchdog counter clears on entry to CONV or SEND and counts every cycle in those states. On reaching TIMEOUT_CYCLES, the block sets `err`=1 and goes to DONE with `count` frozen.
- ACQ_TIMEOUT_EN undefined: no watchdog logic; the block waits indefinitely; `err` is tied 0.

## Test plan
- Reset, limit=3, SAMPLE_PERIOD=24, sampler model returns 0x0A1/0x0B2/0x0C3 → `adc_start` at cycles 24/48/72 after arm; RAM writes to 0,1,2; `tx_data` sequence 0x0A1, 0x0B2, 0x0C3; `done`=1, `count`=3.
- limit=0, arm → DONE on the next cycle with no `adc_start` or `tx_start`; `done`=1, `count`=0.
- limit=127, data = sample index → 127 writes, replay order 0..126; `wr_addr` and `rd_addr` never exceed 126.
- Second arm edge and a `sample_limit` change mid-capture → run continues with the original limit; a post-DONE arm restarts with `count`=0.
- `rst` asserted during SEND → all outputs reach reset values on the next cycle; a late `tx_done` is ignored.
- With ACQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, sampler never answers → `err`=1 and `done`=1 100 cycles after CONV entry, `count`=0. Without the macro → `busy` stays 1.
